// File: rtl/gfx_rom_arbiter_if.sv
// gfx_rom_arbiter_if: requester and ROM-side bus bundle for the graphics ROM arbiter.
// The slave side is the arbiter; the master side is whatever drives the requests and the memory.
interface gfx_rom_arbiter_if;
    logic        cpu_req;
    logic [18:1] cpu_addr;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        tile_req;
    logic [19:0] tile_addr;
    logic [31:0] tile_rdata;
    logic        tile_ack;
    logic        spr_req;
    logic [19:0] spr_addr;
    logic [31:0] spr_rdata;
    logic        spr_ack;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rdy;
    logic        err;
    modport slave (
        input  cpu_req, cpu_addr, tile_req, tile_addr, spr_req, spr_addr, mem_rdata, mem_rdy,
        output cpu_rdata, cpu_ack, tile_rdata, tile_ack, spr_rdata, spr_ack, mem_req, mem_addr, err
    );
    modport master (
        output cpu_req, cpu_addr, tile_req, tile_addr, spr_req, spr_addr, mem_rdata, mem_rdy,
        input  cpu_rdata, cpu_ack, tile_rdata, tile_ack, spr_rdata, spr_ack, mem_req, mem_addr, err
    );
endinterface

// File: rtl/gfx_rom_arbiter.sv
// gfx_rom_arbiter: shares one 32-bit ROM port between the 68k, tile and sprite fetchers.
// Video alternates fairly; the CPU is promoted after CPU_MAX_WAIT lost cycles; stalled reads time out.
module gfx_rom_arbiter #(
    parameter logic [21:0] CPU_BASE     = 22'h000000,
    parameter logic [21:0] TILE_BASE    = 22'h040000,
    parameter logic [21:0] SPR_BASE     = 22'h140000,
    parameter int          CPU_MAX_WAIT = 16,
    parameter int          TIMEOUT      = 255
) (
    input logic            clk_main,
    input logic            nRESET,
    gfx_rom_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] G_CPU   = 2'd0;
    localparam logic [1:0] G_TILE  = 2'd1;
    localparam logic [1:0] G_SPR   = 2'd2;
    localparam int WW = $clog2(CPU_MAX_WAIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    r_state, r_owner;
    logic [2:0]    r_req_d, r_pend, r_ack;
    logic [WW-1:0] r_cpu_wait;
    logic [TW-1:0] r_to_cnt;
    logic          r_last_spr, r_cpu_hi, r_err, r_mem_req;
    logic [21:0]   r_addr;
    logic [15:0]   r_cpu_rdata;
    logic [31:0]   r_tile_rdata, r_spr_rdata;

    logic [2:0]  w_req, w_rise;
    logic        w_cpu_urgent, w_grant, w_cpu_lose, w_finish;
    logic [1:0]  w_sel;
    logic [21:0] w_sel_addr;
    logic [31:0] w_data;

    always_comb begin
        w_req        = {bus.spr_req, bus.tile_req, bus.cpu_req};
        w_rise       = w_req & ~r_req_d;
        w_cpu_urgent = r_pend[0] && (r_cpu_wait >= WW'(CPU_MAX_WAIT));
        w_grant      = (r_state == S_IDLE) && (|r_pend);
        w_sel        = w_cpu_urgent             ? G_CPU :
                       (r_pend[1] && r_pend[2]) ? (r_last_spr ? G_TILE : G_SPR) :
                       r_pend[1]                ? G_TILE :
                       r_pend[2]                ? G_SPR : G_CPU;
        w_sel_addr   = (w_sel == G_CPU)  ? CPU_BASE + {5'd0, bus.cpu_addr[18:2]} :
                       (w_sel == G_TILE) ? TILE_BASE + {2'd0, bus.tile_addr} :
                                           SPR_BASE + {2'd0, bus.spr_addr};
        // a CPU access already in flight is not a lost cycle
        w_cpu_lose   = r_pend[0] && !(w_grant && w_sel == G_CPU) &&
                       !(r_state != S_IDLE && r_owner == G_CPU);
        w_finish     = (r_state == S_ISSUE) && (bus.mem_rdy || r_to_cnt == TW'(TIMEOUT - 1));
        w_data       = bus.mem_rdy ? bus.mem_rdata : '1;
    end

    always_ff @(posedge clk_main or negedge nRESET) begin
        if (!nRESET) begin
            r_state      <= S_IDLE;
            r_owner      <= G_CPU;
            r_req_d      <= '1;
            r_pend       <= '0;
            r_ack        <= '0;
            r_cpu_wait   <= '0;
            r_to_cnt     <= '0;
            r_last_spr   <= 1'b1;
            r_cpu_hi     <= 1'b0;
            r_err        <= 1'b0;
            r_mem_req    <= 1'b0;
            r_addr       <= '0;
            r_cpu_rdata  <= '0;
            r_tile_rdata <= '0;
            r_spr_rdata  <= '0;
        end else begin
            r_req_d <= w_req;
            r_pend  <= (r_pend & ~r_ack) | w_rise;
            r_ack   <= '0;
            if (w_grant && w_sel == G_CPU)
                r_cpu_wait <= '0;
            else if (w_cpu_lose && !w_cpu_urgent)
                r_cpu_wait <= r_cpu_wait + WW'(1);
            if (r_state == S_IDLE) begin
                if (w_grant) begin
                    r_state   <= S_ISSUE;
                    r_owner   <= w_sel;
                    r_addr    <= w_sel_addr;
                    r_mem_req <= 1'b1;
                    r_to_cnt  <= '0;
                    r_cpu_hi  <= bus.cpu_addr[1];
                    if (w_sel != G_CPU)
                        r_last_spr <= (w_sel == G_SPR);
                end
            end else if (r_state == S_ISSUE) begin
                if (w_finish) begin
                    r_state   <= S_DONE;
                    r_mem_req <= 1'b0;
                    r_ack     <= 3'b001 << r_owner;
                    r_err     <= r_err | !bus.mem_rdy;
                    if (r_owner == G_CPU)
                        r_cpu_rdata <= r_cpu_hi ? w_data[31:16] : w_data[15:0];
                    if (r_owner == G_TILE)
                        r_tile_rdata <= w_data;
                    if (r_owner == G_SPR)
                        r_spr_rdata <= w_data;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_addr;
    assign bus.cpu_ack    = r_ack[0];
    assign bus.tile_ack   = r_ack[1];
    assign bus.spr_ack    = r_ack[2];
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.tile_rdata = r_tile_rdata;
    assign bus.spr_rdata  = r_spr_rdata;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// tb_gfx_rom_arbiter: scoreboard bench; expected grants are queued at stimulus time and popped on acks.
// A behavioural ROM answers mem_req with data derived from the address.
module tb_gfx_rom_arbiter;
    localparam logic [21:0] TB_CPU  = 22'h000000;
    localparam logic [21:0] TB_TILE = 22'h040000;
    localparam logic [21:0] TB_SPR  = 22'h140000;

    typedef struct {
        int          id;
        logic [21:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk_main = 1'b0;
    logic nRESET   = 1'b0;
    always #5 clk_main = ~clk_main;

    gfx_rom_arbiter_if bus();
    gfx_rom_arbiter dut (.clk_main(clk_main), .nRESET(nRESET), .bus(bus));

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          acks[3];
    bit          sb_on = 1'b1;
    bit          rdy_en = 1'b1;
    bit          force_rdy = 1'b0;
    bit          stop = 1'b0;
    logic [21:0] last_addr, m_prev_addr;
    logic        m_prev_req;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [21:0] a);
        return (a == 22'h1) ? 32'hAABBCCDD : ({~a[15:0], a[15:0]} ^ 32'h13579BDF);
    endfunction

    task automatic push(input int id, input logic [21:0] a, input logic [31:0] d);
        exp_t e;
        e.id = id;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_cpu(input logic [17:0] ca);
        logic [21:0] a;
        logic [31:0] d;
        a = TB_CPU + {5'd0, ca[17:1]};
        d = mem_data(a);
        push(0, a, ca[0] ? 32'(d[31:16]) : 32'(d[15:0]));
    endtask

    task automatic pulse(input bit c, input bit t, input bit s,
                         input logic [17:0] ca, input logic [19:0] ta, input logic [19:0] sa);
        @(posedge clk_main);
        #1;
        if (c) begin bus.cpu_addr = ca; bus.cpu_req = 1'b1; end
        if (t) begin bus.tile_addr = ta; bus.tile_req = 1'b1; end
        if (s) begin bus.spr_addr = sa; bus.spr_req = 1'b1; end
        @(posedge clk_main);
        #1;
        bus.cpu_req = 1'b0;
        bus.tile_req = 1'b0;
        bus.spr_req = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk_main);
            k++;
        end
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk_main);
    endtask

    // behavioural ROM: answers within the first ISSUE cycle unless stalled
    initial forever begin
        @(negedge clk_main);
        bus.mem_rdy = force_rdy | (rdy_en & bus.mem_req);
        bus.mem_rdata = mem_data(bus.mem_addr);
    end

    initial begin
        logic [2:0]  w;
        logic [31:0] got;
        int          id;
        exp_t        e;
        m_prev_req = 1'b0;
        forever begin
            @(negedge clk_main);
            if (nRESET) begin
                if (bus.mem_req && m_prev_req)
                    chk("addr_hold", 32'(bus.mem_addr), 32'(m_prev_addr));
                if (bus.mem_req)
                    last_addr = bus.mem_addr;
                w = {bus.spr_ack, bus.tile_ack, bus.cpu_ack};
                if (|w) begin
                    chk("ack_onehot", 32'($onehot(w)), 1);
                    id = w[0] ? 0 : w[1] ? 1 : 2;
                    acks[id]++;
                    got = (id == 0) ? 32'(bus.cpu_rdata) : (id == 1) ? bus.tile_rdata : bus.spr_rdata;
                    if (sb_on) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_ack", 32'(w), 0);
                        end else begin
                            e = sb.pop_front();
                            chk("ack_id", id, e.id);
                            chk("mem_addr", 32'(last_addr), 32'(e.addr));
                            chk("rdata", got, e.data);
                        end
                    end
                end
            end
            m_prev_req = bus.mem_req;
            m_prev_addr = bus.mem_addr;
        end
    end

    initial begin
        int k, n_iss, base, vid0, a0;
        acks = '{0, 0, 0};
        bus.cpu_req = 1'b0;
        bus.tile_req = 1'b0;
        bus.spr_req = 1'b0;
        bus.cpu_addr = '0;
        bus.tile_addr = '0;
        bus.spr_addr = '0;
        bus.mem_rdy = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) @(negedge clk_main);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_acks", 32'({bus.spr_ack, bus.tile_ack, bus.cpu_ack}), 0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
        chk("rst_tile_rdata", bus.tile_rdata, 0);
        chk("rst_spr_rdata", bus.spr_rdata, 0);
        chk("rst_err", 32'(bus.err), 0);
        @(posedge clk_main);
        #1 nRESET = 1'b1;
        repeat (2) @(posedge clk_main);

        // CPU-only read with minimum latency and late address change
        push_cpu(18'h00003);
        base = acks[0];
        @(posedge clk_main);
        #1;
        bus.cpu_addr = 18'h00003;
        bus.cpu_req = 1'b1;
        k = 0;
        while (!bus.cpu_ack && k < 20) begin
            @(negedge clk_main);
            k++;
            if (k == 2) bus.cpu_req = 1'b0;
            if (k == 3) bus.cpu_addr = 18'h3FFFF;
        end
        chk("cpu_latency", k, 4);
        repeat (3) @(negedge clk_main);
        chk("cpu_ack_count", acks[0] - base, 1);
        chk("cpu_rdata_hold", 32'(bus.cpu_rdata), 32'h0000AABB);
        drain(10);

        // simultaneous video: tile first after reset, then sprite
        push(1, TB_TILE + 22'h012345, mem_data(TB_TILE + 22'h012345));
        push(2, TB_SPR + 22'h0FFFFF, mem_data(TB_SPR + 22'h0FFFFF));
        pulse(0, 1, 1, 18'h0, 20'h12345, 20'hFFFFF);
        drain(40);

        // after a lone tile, a tie goes to the sprite
        push(1, TB_TILE + 22'h000ABC, mem_data(TB_TILE + 22'h000ABC));
        pulse(0, 1, 0, 18'h0, 20'h00ABC, 20'h0);
        drain(20);
        push(2, TB_SPR + 22'h000001, mem_data(TB_SPR + 22'h000001));
        push(1, TB_TILE + 22'h000002, mem_data(TB_TILE + 22'h000002));
        pulse(0, 1, 1, 18'h0, 20'h00002, 20'h00001);
        drain(40);

        // CPU starvation bound under continuous video traffic
        sb_on = 1'b0;
        stop = 1'b0;
        fork
            begin
                while (!stop) begin
                    @(posedge clk_main);
                    #1;
                    bus.tile_req = ~bus.tile_req;
                    bus.spr_req = ~bus.spr_req;
                end
                bus.tile_req = 1'b0;
                bus.spr_req = 1'b0;
            end
        join_none
        repeat (6) @(posedge clk_main);
        vid0 = acks[1] + acks[2];
        @(posedge clk_main);
        #1;
        bus.cpu_addr = 18'h00010;
        bus.cpu_req = 1'b1;
        k = 0;
        while (!bus.cpu_ack && k < 40) begin
            @(negedge clk_main);
            k++;
            if (k == 2) bus.cpu_req = 1'b0;
        end
        chk("cpu_fair_bound", 32'(k <= 22), 1);
        chk("cpu_wait_clr", 32'(dut.r_cpu_wait), 0);
        chk("video_won", 32'((acks[1] + acks[2] - vid0) > 0), 1);
        stop = 1'b1;
        repeat (30) @(negedge clk_main);
        sb_on = 1'b1;

        // timeout: stalled ROM returns all-ones and sets sticky err
        rdy_en = 1'b0;
        push(1, TB_TILE + 22'h000777, 32'hFFFFFFFF);
        @(posedge clk_main);
        #1;
        bus.tile_addr = 20'h00777;
        bus.tile_req = 1'b1;
        k = 0;
        n_iss = 0;
        while (!bus.tile_ack && k < 400) begin
            @(negedge clk_main);
            k++;
            if (bus.mem_req) n_iss++;
            if (k == 2) bus.tile_req = 1'b0;
        end
        chk("timeout_cycles", n_iss, 255);
        chk("err_set", 32'(bus.err), 1);
        rdy_en = 1'b1;
        repeat (2) @(negedge clk_main);
        push_cpu(18'h00010);
        pulse(1, 0, 0, 18'h00010, 20'h0, 20'h0);
        drain(20);
        chk("err_sticky", 32'(bus.err), 1);

        // reset during ISSUE aborts silently; held-high requests are not served
        rdy_en = 1'b0;
        @(posedge clk_main);
        #1;
        bus.tile_addr = 20'h00005;
        bus.tile_req = 1'b1;
        bus.cpu_req = 1'b1;
        k = 0;
        while (!bus.mem_req && k < 10) begin
            @(negedge clk_main);
            k++;
        end
        chk("rst_issue_reached", 32'(bus.mem_req), 1);
        repeat (3) @(negedge clk_main);
        a0 = acks[0] + acks[1] + acks[2];
        #1 nRESET = 1'b0;
        @(negedge clk_main);
        chk("rst2_mem_req", 32'(bus.mem_req), 0);
        chk("rst2_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst2_acks", 32'({bus.spr_ack, bus.tile_ack, bus.cpu_ack}), 0);
        chk("rst2_cpu_rdata", 32'(bus.cpu_rdata), 0);
        chk("rst2_tile_rdata", bus.tile_rdata, 0);
        chk("rst2_spr_rdata", bus.spr_rdata, 0);
        chk("rst2_err", 32'(bus.err), 0);
        @(posedge clk_main);
        #1;
        nRESET = 1'b1;
        force_rdy = 1'b1;
        rdy_en = 1'b1;
        repeat (2) @(posedge clk_main);
        #1 force_rdy = 1'b0;
        repeat (20) @(negedge clk_main);
        chk("rst2_no_ack", acks[0] + acks[1] + acks[2] - a0, 0);
        chk("rst2_no_mem_req", 32'(bus.mem_req), 0);
        chk("rst2_err_after", 32'(bus.err), 0);
        bus.cpu_req = 1'b0;
        bus.tile_req = 1'b0;
        repeat (2) @(negedge clk_main);
        push(1, TB_TILE + 22'h000006, mem_data(TB_TILE + 22'h000006));
        pulse(0, 1, 0, 18'h0, 20'h00006, 20'h0);
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gfx_rom_arbiter.md
GFX_ROM_ARBITER -- requirements
Module: gfx_rom_arbiter

Interface
REQ-001 SHALL have parameter CPU_BASE, default 22'h000000, meaning the 32-bit-word base of the 68k program ROM region.
REQ-002 SHALL have parameter TILE_BASE, default 22'h040000, meaning the 32-bit-word base of the tile (plane) ROM region.
REQ-003 SHALL have parameter SPR_BASE, default 22'h140000, meaning the 32-bit-word base of the sprite ROM region.
REQ-004 SHALL have parameter CPU_MAX_WAIT, default 16, meaning the number of cycles the CPU may lose arbitration before it is promoted.
REQ-005 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles in ISSUE before the access is aborted.
REQ-006 SHALL have port clk_main, input, width 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port nRESET, input, width 1: the reset, which is asynchronous and active-low.
REQ-008 SHALL have ports cpu_req (in, 1), cpu_addr (in, 18, word address A[18:1]), cpu_rdata (out, 16) and cpu_ack (out, 1).
REQ-009 SHALL have ports tile_req (in, 1), tile_addr (in, 20), tile_rdata (out, 32) and tile_ack (out, 1).
REQ-010 SHALL have ports spr_req (in, 1), spr_addr (in, 20), spr_rdata (out, 32) and spr_ack (out, 1).
REQ-011 SHALL have ports mem_req (out, 1), mem_addr (out, 22), mem_rdata (in, 32), mem_rdy (in, 1) and err (out, 1, sticky timeout flag).

Function
REQ-012 SHALL latch a pending flag per requester on a rising edge of its req (req high, previous-cycle req low).
REQ-013 SHALL clear a pending flag in the cycle its ack is asserted; a rising edge in that same cycle re-sets the flag.
REQ-014 SHALL use a state machine IDLE -> ISSUE -> DONE -> IDLE; only IDLE arbitrates.
REQ-015 In IDLE, priority SHALL be: CPU if cpu_wait >= CPU_MAX_WAIT; else tile/sprite; else CPU.
REQ-016 When both tile and sprite are pending, the grant SHALL go to the one not granted most recently; the last-video flag resets to "sprite" so that tile wins first.
REQ-017 cpu_wait SHALL increment (saturating at CPU_MAX_WAIT) on each IDLE or busy cycle while CPU is pending and not granted, and SHALL clear on CPU grant.
REQ-018 On grant, SHALL enter ISSUE next cycle with mem_req=1 and mem_addr held stable until exit from ISSUE.
REQ-019 mem_addr SHALL be CPU_BASE+cpu_addr[18:2], TILE_BASE+tile_addr or SPR_BASE+spr_addr, summed modulo 2^22.
REQ-020 Addresses SHALL be captured at grant; later changes on *_addr SHALL be ignored.
REQ-021 On mem_rdy=1 in ISSUE, SHALL register mem_rdata, drop mem_req next cycle and enter DONE.
REQ-022 In DONE, exactly one ack SHALL be high for one cycle, with the matching rdata valid and held until that requester's next ack.
REQ-023 cpu_rdata SHALL be mem_rdata[31:16] when the captured cpu_addr[1]=1, else mem_rdata[15:0].
REQ-024 If ISSUE lasts TIMEOUT cycles without mem_rdy, SHALL enter DONE with rdata all-ones and set err; err clears only on reset.
REQ-025 mem_rdy outside ISSUE SHALL be ignored.
REQ-026 Minimum latency SHALL be: pending at IDLE cycle N, mem_req at N+1, ack at N+2 when mem_rdy arrives at N+1.

Reset
REQ-027 While nRESET=0, SHALL force IDLE, clear all pending flags, cpu_wait and err, and drive mem_req=0, mem_addr=0, all acks=0 and all rdata=0.
REQ-028 Reset asserted mid-ISSUE SHALL abort the access without an ack; a mem_rdy arriving after release SHALL be ignored.
REQ-029 Requester req signals held high through reset release SHALL NOT create a request until they fall and rise again.

Verification
REQ-030 CPU-only test: pulse cpu_req with cpu_addr=18'h00003, mem_rdy=1 one cycle after mem_req, mem_rdata=32'hAABBCCDD -> mem_addr=22'h000001, cpu_rdata=16'hAABB, single cpu_ack.
REQ-031 Tile and sprite raised in the same cycle -> tile served first, then sprite; mem_addr=TILE_BASE+tile_addr, then SPR_BASE+spr_addr.
REQ-032 Video requests continuously pending with CPU pending -> CPU granted no later than the arbitration after 16 lost cycles; cpu_wait then cleared.
REQ-033 mem_rdy held low -> after 255 ISSUE cycles the ack fires with rdata=all-ones and err=1, and err stays 1 until nRESET.
REQ-034 nRESET pulsed low during ISSUE -> no ack; all outputs are 0 and err=0 after release; held-high req lines are not served.
